jk_ff_checker: RTL and testbench

- Synthesizable, self-checking monitor for any JK flip-flop implementation on the same clock, including JK built from D, T or SR flip-flops.
- Observes the J/K inputs and the Q/QBAR outputs of the device under check. Runs an internal JK reference model, flags mismatches, and keeps per-mode coverage and error counters.
- Sits beside the flip-flop in benches and on-chip debug wrappers. It is the consumer/judge of the J/K stimulus stream.

---
 rtl/jk_ff_checker_if.sv | 35 +++
 rtl/jk_ff_checker.sv | 145 ++++++++++++++
 tb/tb_jk_ff_checker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/jk_ff_checker_if.sv
// Bundle of the signals exchanged between a JK flip-flop bench (or debug
// wrapper) and the jk_ff_checker monitor. The master side drives the J/K
// stimulus and the observed DUT outputs. The slave side is the checker, which
// returns its prediction, status and counters.
interface jk_ff_checker_if #(
    parameter int unsigned CNT_W = 8
);
    // Stimulus and observed DUT state
    logic             en;
    logic             dut_reset;
    logic             j;
    logic             k;
    logic             q;
    logic             qbar;

    // Checker results
    logic             exp_q;
    logic [1:0]       mode;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] tog_cnt;
    logic [1:0]       state;

    modport master (
        output en, dut_reset, j, k, q, qbar,
        input  exp_q, mode, err, err_sticky, err_cnt, chk_cnt, tog_cnt, state
    );

    modport slave (
        input  en, dut_reset, j, k, q, qbar,
        output exp_q, mode, err, err_sticky, err_cnt, chk_cnt, tog_cnt, state
    );
endinterface

// File: rtl/jk_ff_checker.sv
// Self-checking monitor for a JK flip-flop that runs on the same clock.
// The module runs a JK reference model beside the device under check. It
// compares the model against the observed Q/QBAR and keeps saturating
// coverage and error counters.
//
// Optional build macro JK_CHK_RESYNC_EN: when defined, a mismatch re-seeds the
// model from the observed q. A single DUT glitch then yields a single error.
// When undefined, the model always advances from its own prediction.
module jk_ff_checker #(
    parameter int unsigned CNT_W = 8
) (
    input logic            clk,
    input logic            reset,
    jk_ff_checker_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StSync  = 2'b01,
        StCheck = 2'b10
    } state_e;

    localparam logic [1:0] ModeToggle = 2'b11;

    state_e           state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;

    logic [1:0]       jk;
    logic             mismatch;
    logic             seed;

    // JK next-state function: hold, reset, set, toggle.
    function automatic logic jk_next(input logic x, input logic [1:0] jk_v);
        logic r;
        unique case (jk_v)
            2'b00:   r = x;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~x;
        endcase
        return r;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign jk = {bus.j, bus.k};

    // A legal DUT must match the model, and qbar must be the complement of q.
    assign mismatch = (bus.q != exp_q_q) || (bus.qbar != ~bus.q);

    // Choose the value the model advances from on a checked cycle.
`ifdef JK_CHK_RESYNC_EN
    assign seed = mismatch ? bus.q : exp_q_q;
`else
    assign seed = exp_q_q;
`endif

    // Next-state logic for the FSM, the reference model and the counters.
    always_comb begin
        state_d   = state_q;
        exp_q_d   = exp_q_q;
        mode_d    = mode_q;
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        chk_cnt_d = chk_cnt_q;
        tog_cnt_d = tog_cnt_q;

        if (!bus.en) begin
            // Idle freezes everything except the one-cycle err pulse.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSync;
                end
                StSync: begin
                    // DUT state is unknown here, so seed the model from q
                    // without comparing.
                    exp_q_d = bus.dut_reset ? 1'b0 : jk_next(bus.q, jk);
                    mode_d  = jk;
                    state_d = StCheck;
                end
                StCheck: begin
                    err_d     = mismatch;
                    chk_cnt_d = sat_inc(chk_cnt_q);
                    if (mismatch) begin
                        sticky_d  = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    if (jk == ModeToggle) begin
                        tog_cnt_d = sat_inc(tog_cnt_q);
                    end
                    mode_d  = jk;
                    exp_q_d = bus.dut_reset ? 1'b0 : jk_next(seed, jk);
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous reset. Reset overrides en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            exp_q_q   <= 1'b0;
            mode_q    <= 2'b00;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
            chk_cnt_q <= '0;
            tog_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q_q   <= exp_q_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
            chk_cnt_q <= chk_cnt_d;
            tog_cnt_q <= tog_cnt_d;
        end
    end

    assign bus.exp_q      = exp_q_q;
    assign bus.mode       = mode_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.chk_cnt    = chk_cnt_q;
    assign bus.tog_cnt    = tog_cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker. The vectors use hand-computed expectations.
module tb_jk_ff_checker;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    jk_ff_checker_if #(.CNT_W(CNT_W)) bus ();

    jk_ff_checker #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test 1 vectors: J/K per edge (SYNC first), q driven before each edge,
    // and exp_q expected after each edge.
    logic [1:0] jk1  [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11};
    logic       q1   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp1 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    // Test 2: toggle run seeded from q=1 at SYNC.
    logic       q2   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp2 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic jv, input logic kv, input logic qv, input logic qbv);
        bus.j    = jv;
        bus.k    = kv;
        bus.q    = qv;
        bus.qbar = qbv;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.dut_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b0;

        check_val("rst_state", 32'(bus.state), 32'd0);
        check_val("rst_exp_q", 32'(bus.exp_q), 32'd0);
        check_val("rst_mode", 32'(bus.mode), 32'd0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        check_val("rst_sticky", 32'(bus.err_sticky), 32'd0);
        check_val("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_val("rst_chk_cnt", 32'(bus.chk_cnt), 32'd0);
        check_val("rst_tog_cnt", 32'(bus.tog_cnt), 32'd0);

        // Test 1: correct DUT through hold/reset/set/toggle.
        bus.en = 1'b1;
        tick();
        check_val("t1_sync_state", 32'(bus.state), 32'd1);
        for (int i = 0; i < 7; i++) begin
            drive(jk1[i][1], jk1[i][0], q1[i], ~q1[i]);
            tick();
            check_val("t1_exp_q", 32'(bus.exp_q), 32'(exp1[i]));
            check_val("t1_mode", 32'(bus.mode), 32'(jk1[i]));
            check_val("t1_err", 32'(bus.err), 32'd0);
            check_val("t1_state", 32'(bus.state), 32'd2);
        end
        check_val("t1_chk_cnt", 32'(bus.chk_cnt), 32'd6);
        check_val("t1_tog_cnt", 32'(bus.tog_cnt), 32'd2);
        check_val("t1_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_val("t1_sticky", 32'(bus.err_sticky), 32'd0);

        // Test 2: toggle run from q=1.
        reset_pulse();
        tick();
        check_val("t2_sync_state", 32'(bus.state), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_val("t2_sync_exp", 32'(bus.exp_q), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, q2[i], ~q2[i]);
            tick();
            check_val("t2_exp_q", 32'(bus.exp_q), 32'(exp2[i]));
            check_val("t2_err", 32'(bus.err), 32'd0);
        end
        check_val("t2_tog_cnt", 32'(bus.tog_cnt), 32'd4);
        check_val("t2_err_cnt", 32'(bus.err_cnt), 32'd0);

        // Test 3: DUT ignores toggle, holding q=1.
        reset_pulse();
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("t3_seed_exp", 32'(bus.exp_q), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_val("t3_e1_err", 32'(bus.err), 32'd0);
        check_val("t3_e1_exp", 32'(bus.exp_q), 32'd0);
        tick();
        check_val("t3_e2_err", 32'(bus.err), 32'd1);
`ifdef JK_CHK_RESYNC_EN
        check_val("t3_e2_exp", 32'(bus.exp_q), 32'd0);
        tick();
        check_val("t3_e3_err", 32'(bus.err), 32'd1);
        check_val("t3_err_cnt", 32'(bus.err_cnt), 32'd2);
`else
        check_val("t3_e2_exp", 32'(bus.exp_q), 32'd1);
        tick();
        check_val("t3_e3_err", 32'(bus.err), 32'd0);
        check_val("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif
        check_val("t3_sticky", 32'(bus.err_sticky), 32'd1);
        check_val("t3_chk_cnt", 32'(bus.chk_cnt), 32'd3);
        check_val("t3_tog_cnt", 32'(bus.tog_cnt), 32'd3);

        // Drop en for 3 cycles with an illegal q/qbar: nothing may move.
        bus.en = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t3_idle_state", 32'(bus.state), 32'd0);
            check_val("t3_idle_err", 32'(bus.err), 32'd0);
            check_val("t3_idle_chk", 32'(bus.chk_cnt), 32'd3);
            check_val("t3_idle_sticky", 32'(bus.err_sticky), 32'd1);
        end
`ifdef JK_CHK_RESYNC_EN
        check_val("t3_idle_err_cnt", 32'(bus.err_cnt), 32'd2);
`else
        check_val("t3_idle_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif
        // Re-enable: one SYNC cycle without a compare, then CHECK.
        bus.en = 1'b1;
        tick();
        check_val("t3_reen_sync", 32'(bus.state), 32'd1);
        tick();
        check_val("t3_reen_check", 32'(bus.state), 32'd2);
        check_val("t3_reen_err", 32'(bus.err), 32'd0);
        check_val("t3_reen_chk", 32'(bus.chk_cnt), 32'd3);

        // Reset mid-CHECK while a mismatch is present.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t3_mid_rst_state", 32'(bus.state), 32'd0);
        check_val("t3_mid_rst_err", 32'(bus.err), 32'd0);
        check_val("t3_mid_rst_sticky", 32'(bus.err_sticky), 32'd0);
        check_val("t3_mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_val("t3_mid_rst_chk", 32'(bus.chk_cnt), 32'd0);
        check_val("t3_mid_rst_tog", 32'(bus.tog_cnt), 32'd0);
        check_val("t3_mid_rst_mode", 32'(bus.mode), 32'd0);

        // Test 4: dut_reset for 2 cycles with J/K=10, DUT stuck at 1.
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("t4_seed_exp", 32'(bus.exp_q), 32'd1);
        bus.dut_reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("t4_e1_err", 32'(bus.err), 32'd0);
        check_val("t4_e1_exp", 32'(bus.exp_q), 32'd0);
        tick();
        check_val("t4_e2_err", 32'(bus.err), 32'd1);
        check_val("t4_e2_exp", 32'(bus.exp_q), 32'd0);
        bus.dut_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("t4_e3_err", 32'(bus.err), 32'd1);
        check_val("t4_err_cnt", 32'(bus.err_cnt), 32'd2);

        // Test 5: qbar equal to q on every cycle; counters must saturate.
        reset_pulse();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t5_sync_err", 32'(bus.err), 32'd0);
        for (int i = 1; i <= 260; i++) begin
            tick();
            check_val("t5_err", 32'(bus.err), 32'd1);
            check_val("t5_err_cnt", 32'(bus.err_cnt), (i > 255) ? 32'd255 : 32'(i));
        end
        check_val("t5_sat_err_cnt", 32'(bus.err_cnt), 32'd255);
        check_val("t5_sat_chk_cnt", 32'(bus.chk_cnt), 32'd255);
        check_val("t5_sticky", 32'(bus.err_sticky), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
